// File: rtl/jala_isa_pkg.sv
// rtl/jala_isa_pkg.sv - JALA opcodes, control-select encodings, op classes and FSM state enum
package jala_isa_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_BZ    = 4'h7;
  localparam logic [3:0] OP_CALL  = 4'h8;
  localparam logic [3:0] OP_RET   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] MEMDST1_PC  = 2'd0;
  localparam logic [1:0] MEMDST1_MSP = 2'd1;
  localparam logic [1:0] MEMDST2_MSP = 2'd0;
  localparam logic [1:0] MEMDST2_RSP = 2'd1;

  localparam logic [2:0] MEMDATA_PC  = 3'd0;
  localparam logic [2:0] MEMDATA_RES = 3'd1;
  localparam logic [2:0] MEMDATA_IMM = 3'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    POPB     = 4'd2,
    POPA     = 4'd3,
    EXEC     = 4'd4,
    PUSHINC  = 4'd5,
    PUSHWR   = 4'd6,
    JUMP     = 4'd7,
    BRANCH   = 4'd8,
    RPUSHINC = 4'd9,
    RPUSHWR  = 4'd10,
    RPOP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_PUSHI, CLS_ALU, CLS_JMP, CLS_BZ, CLS_CALL, CLS_RET, CLS_HALT, CLS_ILLEGAL
  } opClass_t;

  function automatic logic [1:0] aluOpOf(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/jala_op_decode.sv
// rtl/jala_op_decode.sv - classifies the 4-bit opcode into the control unit's instruction classes
module jala_op_decode
  import jala_isa_pkg::*;
(
  input  logic [3:0] op,
  output opClass_t   opClass
);

  always_comb begin
    opClass = CLS_ILLEGAL;
    case (op)
      OP_NOP:                        opClass = CLS_NOP;
      OP_PUSHI:                      opClass = CLS_PUSHI;
      OP_ADD, OP_SUB, OP_AND, OP_OR: opClass = CLS_ALU;
      OP_JMP:                        opClass = CLS_JMP;
      OP_BZ:                         opClass = CLS_BZ;
      OP_CALL:                       opClass = CLS_CALL;
      OP_RET:                        opClass = CLS_RET;
      OP_HALT:                       opClass = CLS_HALT;
      default:                       opClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/jala_control_fsm.sv
// rtl/jala_control_fsm.sv - multicycle fetch/decode/execute control unit for the JALA stack CPU
module jala_control_fsm
  import jala_isa_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] IR,
  input  logic             ValAZero,
  output logic             MSPWrite,
  output logic             MSPPop,
  output logic             RSPWrite,
  output logic             RSPPop,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             PCAdd,
  output logic             ValAWrite,
  output logic             ValBWrite,
  output logic             IRWrite,
  output logic             MemRead1,
  output logic             MemRead2,
  output logic             MemWrite1,
  output logic             MemWrite2,
  output logic [1:0]       MemDst1,
  output logic [1:0]       MemDst2,
  output logic [2:0]       MemData,
  output logic [1:0]       AluOp,
  output logic             ResWrite,
  output logic             Halted,
  output logic [3:0]       State
);

  state_t     state;
  state_t     nextState;
  opClass_t   opClass;
  logic [3:0] op;
  logic       unusedImm;

  assign op        = IR[WIDTH-1 -: 4];
  assign unusedImm = ^IR[WIDTH-5:0];
  assign State     = state;

  jala_op_decode uDecode (
    .op      (op),
    .opClass (opClass)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    nextState = DECODE;
      DECODE: begin
        case (opClass)
          CLS_NOP:     nextState = FETCH;
          CLS_PUSHI:   nextState = PUSHINC;
          CLS_ALU:     nextState = POPB;
          CLS_JMP,
          CLS_BZ:      nextState = POPA;
          CLS_CALL:    nextState = RPUSHINC;
          CLS_RET:     nextState = RPOP;
          CLS_ILLEGAL: nextState = HALT_ON_ILLEGAL ? HALT : FETCH;
          default:     nextState = HALT;
        endcase
      end
      POPB:     nextState = POPA;
      POPA: begin
        case (opClass)
          CLS_ALU: nextState = EXEC;
          CLS_JMP: nextState = JUMP;
          CLS_BZ:  nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      EXEC:     nextState = PUSHINC;
      PUSHINC:  nextState = PUSHWR;
      PUSHWR:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      BRANCH:   nextState = FETCH;
      RPUSHINC: nextState = RPUSHWR;
      RPUSHWR:  nextState = FETCH;
      RPOP:     nextState = JUMP;
      HALT:     nextState = HALT;
      default:  nextState = FETCH;
    endcase
  end

  // Reset forces every strobe low so an abandoned instruction cannot touch PC or stacks.
  always_comb begin
    MSPWrite  = 1'b0;
    MSPPop    = 1'b0;
    RSPWrite  = 1'b0;
    RSPPop    = 1'b0;
    PCWrite   = 1'b0;
    PCSource  = 1'b0;
    PCAdd     = 1'b0;
    ValAWrite = 1'b0;
    ValBWrite = 1'b0;
    IRWrite   = 1'b0;
    MemRead1  = 1'b0;
    MemRead2  = 1'b0;
    MemWrite1 = 1'b0;
    MemWrite2 = 1'b0;
    MemDst1   = MEMDST1_PC;
    MemDst2   = MEMDST2_MSP;
    MemData   = MEMDATA_PC;
    AluOp     = ALU_ADD;
    ResWrite  = 1'b0;
    Halted    = 1'b0;
    if (!Reset) begin
      case (state)
        FETCH: begin
          MemRead1 = 1'b1;
          MemDst1  = MEMDST1_PC;
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
        end
        POPB: begin
          MemRead2  = 1'b1;
          MemDst2   = MEMDST2_MSP;
          ValBWrite = 1'b1;
          MSPWrite  = 1'b1;
          MSPPop    = 1'b1;
        end
        POPA: begin
          MemRead2  = 1'b1;
          MemDst2   = MEMDST2_MSP;
          ValAWrite = 1'b1;
          MSPWrite  = 1'b1;
          MSPPop    = 1'b1;
        end
        EXEC: begin
          AluOp    = aluOpOf(op);
          ResWrite = 1'b1;
        end
        PUSHINC:  MSPWrite = 1'b1;
        PUSHWR: begin
          MemWrite2 = 1'b1;
          MemDst2   = MEMDST2_MSP;
          MemData   = (opClass == CLS_ALU) ? MEMDATA_RES : MEMDATA_IMM;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 1'b1;
        end
        // Offset applies to the PC already advanced during FETCH.
        BRANCH: begin
          PCWrite = ValAZero;
          PCAdd   = 1'b1;
        end
        RPUSHINC: RSPWrite = 1'b1;
        RPUSHWR: begin
          MemWrite2 = 1'b1;
          MemDst2   = MEMDST2_RSP;
          MemData   = MEMDATA_PC;
          PCWrite   = 1'b1;
          PCAdd     = 1'b1;
        end
        RPOP: begin
          MemRead2  = 1'b1;
          MemDst2   = MEMDST2_RSP;
          ValAWrite = 1'b1;
          RSPWrite  = 1'b1;
          RSPPop    = 1'b1;
        end
        HALT:     Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jala_control_fsm.sv
// tb/tb_jala_control_fsm.sv - self-checking bench for jala_control_fsm against a per-instruction phase model
module tb_jala_control_fsm;
  import jala_isa_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        ValAZero = 1'b0;

  always #5 CLK = ~CLK;

  // Index 0: HALT_ON_ILLEGAL=1 instance, index 1: HALT_ON_ILLEGAL=0 instance.
  logic [1:0] mspWrite, mspPop, rspWrite, rspPop, pcWrite, pcSource, pcAdd, valAWrite, valBWrite;
  logic [1:0] irWrite, memRead1, memRead2, memWrite1, memWrite2, resWrite, halted;
  logic [1:0] memDst1 [2];
  logic [1:0] memDst2 [2];
  logic [2:0] memData [2];
  logic [1:0] aluOp [2];
  logic [3:0] state [2];

  jala_control_fsm #(.WIDTH(16), .HALT_ON_ILLEGAL(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .IR(IR), .ValAZero(ValAZero),
    .MSPWrite(mspWrite[0]), .MSPPop(mspPop[0]), .RSPWrite(rspWrite[0]), .RSPPop(rspPop[0]),
    .PCWrite(pcWrite[0]), .PCSource(pcSource[0]), .PCAdd(pcAdd[0]),
    .ValAWrite(valAWrite[0]), .ValBWrite(valBWrite[0]), .IRWrite(irWrite[0]),
    .MemRead1(memRead1[0]), .MemRead2(memRead2[0]), .MemWrite1(memWrite1[0]), .MemWrite2(memWrite2[0]),
    .MemDst1(memDst1[0]), .MemDst2(memDst2[0]), .MemData(memData[0]), .AluOp(aluOp[0]),
    .ResWrite(resWrite[0]), .Halted(halted[0]), .State(state[0])
  );

  jala_control_fsm #(.WIDTH(16), .HALT_ON_ILLEGAL(1'b0)) dutNop (
    .CLK(CLK), .Reset(Reset), .IR(IR), .ValAZero(ValAZero),
    .MSPWrite(mspWrite[1]), .MSPPop(mspPop[1]), .RSPWrite(rspWrite[1]), .RSPPop(rspPop[1]),
    .PCWrite(pcWrite[1]), .PCSource(pcSource[1]), .PCAdd(pcAdd[1]),
    .ValAWrite(valAWrite[1]), .ValBWrite(valBWrite[1]), .IRWrite(irWrite[1]),
    .MemRead1(memRead1[1]), .MemRead2(memRead2[1]), .MemWrite1(memWrite1[1]), .MemWrite2(memWrite2[1]),
    .MemDst1(memDst1[1]), .MemDst2(memDst2[1]), .MemData(memData[1]), .AluOp(aluOp[1]),
    .ResWrite(resWrite[1]), .Halted(halted[1]), .State(state[1])
  );

  typedef struct packed {
    logic       mspWrite, mspPop, rspWrite, rspPop, pcWrite, pcSource, pcAdd;
    logic       valAWrite, valBWrite, irWrite, memRead1, memRead2, memWrite1, memWrite2;
    logic [1:0] memDst1;
    logic [1:0] memDst2;
    logic [2:0] memData;
    logic [1:0] aluOp;
    logic       resWrite, halted;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    obs_t  o;
    bit    chkState;
    string tag;
  } exp_t;

  typedef enum {P_FETCH, P_DECODE, P_POPB, P_POPA, P_EXEC, P_PUSHINC, P_PUSHWR, P_JUMP,
                P_BRANCH, P_RPUSHINC, P_RPUSHWR, P_RPOP, P_HALT, P_RESET} phase_e;

  exp_t       expQ[$];
  obs_t       trace[$];
  logic [3:0] nopTrace[$];
  int         nTests = 0;
  int         nFail = 0;
  bit         chkEn = 1'b0;

  function automatic obs_t obsOf(input int i);
    obs_t o;
    o.mspWrite = mspWrite[i];   o.mspPop = mspPop[i];     o.rspWrite = rspWrite[i];
    o.rspPop = rspPop[i];       o.pcWrite = pcWrite[i];   o.pcSource = pcSource[i];
    o.pcAdd = pcAdd[i];         o.valAWrite = valAWrite[i]; o.valBWrite = valBWrite[i];
    o.irWrite = irWrite[i];     o.memRead1 = memRead1[i]; o.memRead2 = memRead2[i];
    o.memWrite1 = memWrite1[i]; o.memWrite2 = memWrite2[i];
    o.memDst1 = memDst1[i];     o.memDst2 = memDst2[i];   o.memData = memData[i];
    o.aluOp = aluOp[i];         o.resWrite = resWrite[i]; o.halted = halted[i];
    o.state = state[i];
    return o;
  endfunction

  // Outputs implied by the action table for one cycle of an instruction.
  function automatic obs_t modelOut(input phase_e p, input logic [3:0] op, input bit z);
    obs_t o = '0;
    case (p)
      P_FETCH:    begin o.memRead1 = 1; o.irWrite = 1; o.pcWrite = 1; o.state = FETCH; end
      P_DECODE:   o.state = DECODE;
      P_POPB:     begin o.memRead2 = 1; o.valBWrite = 1; o.mspWrite = 1; o.mspPop = 1; o.state = POPB; end
      P_POPA:     begin o.memRead2 = 1; o.valAWrite = 1; o.mspWrite = 1; o.mspPop = 1; o.state = POPA; end
      P_EXEC:     begin o.aluOp = 2'(op - 4'd2); o.resWrite = 1; o.state = EXEC; end
      P_PUSHINC:  begin o.mspWrite = 1; o.state = PUSHINC; end
      P_PUSHWR:   begin o.memWrite2 = 1; o.memData = (op == 4'h1) ? 3'd2 : 3'd1; o.state = PUSHWR; end
      P_JUMP:     begin o.pcWrite = 1; o.pcSource = 1; o.state = JUMP; end
      P_BRANCH:   begin o.pcWrite = z; o.pcAdd = 1; o.state = BRANCH; end
      P_RPUSHINC: begin o.rspWrite = 1; o.state = RPUSHINC; end
      P_RPUSHWR:  begin o.memWrite2 = 1; o.memDst2 = 2'd1; o.pcWrite = 1; o.pcAdd = 1; o.state = RPUSHWR; end
      P_RPOP:     begin o.memRead2 = 1; o.memDst2 = 2'd1; o.valAWrite = 1; o.rspWrite = 1; o.rspPop = 1; o.state = RPOP; end
      P_HALT:     begin o.halted = 1; o.state = HALT; end
      default:    o.state = FETCH;
    endcase
    return o;
  endfunction

  task automatic expPush(input phase_e p, input logic [3:0] op, input bit z, input bit cs);
    exp_t e;
    e.o = modelOut(p, op, z);
    e.chkState = cs;
    e.tag = p.name();
    expQ.push_back(e);
  endtask

  task automatic planInstr(input logic [15:0] ir, input bit z, input int haltCycles);
    logic [3:0] op;
    op = ir[15:12];
    expPush(P_FETCH, op, z, 1);
    expPush(P_DECODE, op, z, 1);
    if (op == 4'h0) begin
    end else if (op == 4'h1) begin
      expPush(P_PUSHINC, op, z, 1); expPush(P_PUSHWR, op, z, 1);
    end else if (op >= 4'h2 && op <= 4'h5) begin
      expPush(P_POPB, op, z, 1); expPush(P_POPA, op, z, 1); expPush(P_EXEC, op, z, 1);
      expPush(P_PUSHINC, op, z, 1); expPush(P_PUSHWR, op, z, 1);
    end else if (op == 4'h6) begin
      expPush(P_POPA, op, z, 1); expPush(P_JUMP, op, z, 1);
    end else if (op == 4'h7) begin
      expPush(P_POPA, op, z, 1); expPush(P_BRANCH, op, z, 1);
    end else if (op == 4'h8) begin
      expPush(P_RPUSHINC, op, z, 1); expPush(P_RPUSHWR, op, z, 1);
    end else if (op == 4'h9) begin
      expPush(P_RPOP, op, z, 1); expPush(P_JUMP, op, z, 1);
    end else begin
      repeat (haltCycles) expPush(P_HALT, op, z, 1);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin : cmp
    obs_t a;
    exp_t e;
    if (chkEn) begin
      a = obsOf(0);
      trace.push_back(a);
      nopTrace.push_back(state[1]);
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL cyc_noexp: got %h want no cycle", a);
      end else begin
        e = expQ.pop_front();
        if (!e.chkState) a.state = e.o.state;
        if (a !== e.o) begin
          nFail++;
          $display("FAIL cyc_%s: got %h want %h", e.tag, a, e.o);
        end
      end
    end
  end

  task automatic runInstr(input string name, input logic [15:0] ir, input bit z,
                          input int lat, input int haltCycles);
    int n0;
    IR = ir;
    ValAZero = z;
    trace.delete();
    nopTrace.delete();
    n0 = expQ.size();
    planInstr(ir, z, haltCycles);
    chk({name, "_lat"}, expQ.size() - n0, lat);
    repeat (lat) @(posedge CLK);
    #1;
  endtask

  task automatic doReset(input int n, input bit stateKnown);
    Reset = 1'b1;
    trace.delete();
    repeat (n) expPush(P_RESET, 4'h0, 1'b0, stateKnown);
    repeat (n) @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_state", state[0], FETCH);
    chk("rst_halted", halted[0], 0);
    chk("rst_nop_state", state[1], FETCH);
  endtask

  initial begin
    obs_t h;
    @(posedge CLK);
    #1;
    chkEn = 1'b1;
    doReset(2, 1'b1);

    runInstr("nop", 16'h0000, 0, 2, 0);
    chk("nop_back", state[0], FETCH);

    runInstr("pushi", 16'h1ABC, 0, 4, 0);
    chk("pushi_inc", {trace[2].mspWrite, trace[2].mspPop}, 2'b10);
    chk("pushi_wr", {trace[3].memWrite2, trace[3].memDst2, trace[3].memData}, {1'b1, 2'd0, 3'd2});

    runInstr("add", 16'h2000, 0, 7, 0);
    chk("add_pops", {trace[2].mspPop, trace[3].mspPop, trace[2].valBWrite, trace[3].valAWrite}, 4'b1111);
    chk("add_exec", {trace[4].aluOp, trace[4].resWrite}, {2'd0, 1'b1});
    chk("add_wr", trace[6].memData, 3'd1);

    runInstr("sub", 16'h3000, 0, 7, 0);
    chk("sub_alu", trace[4].aluOp, 2'd1);
    runInstr("and", 16'h4FFF, 0, 7, 0);
    runInstr("or", 16'h5123, 0, 7, 0);
    chk("or_alu", trace[4].aluOp, 2'd3);

    runInstr("bz_taken", 16'h7FFE, 1, 4, 0);
    chk("bz_taken_pc", {trace[3].pcWrite, trace[3].pcAdd, trace[3].pcSource}, 3'b110);
    runInstr("bz_not", 16'h7FFE, 0, 4, 0);
    chk("bz_not_pc", trace[3].pcWrite, 1'b0);
    chk("bz_back", state[0], FETCH);

    runInstr("jmp", 16'h6000, 0, 4, 0);
    chk("jmp_src", {trace[3].pcWrite, trace[3].pcSource}, 2'b11);

    runInstr("call", 16'h8010, 0, 4, 0);
    chk("call_wr", {trace[3].memDst2, trace[3].memData, trace[3].pcAdd}, {2'd1, 3'd0, 1'b1});
    runInstr("ret", 16'h9000, 0, 4, 0);
    chk("ret_pop", {trace[2].rspPop, trace[2].valAWrite}, 2'b11);
    chk("ret_jump", trace[3].pcSource, 1'b1);

    // Abandon an ALU op after its first pop; reset spans two cycles.
    IR = 16'h2000;
    trace.delete();
    expPush(P_FETCH, 4'h2, 0, 1);
    expPush(P_DECODE, 4'h2, 0, 1);
    expPush(P_POPB, 4'h2, 0, 1);
    repeat (3) @(posedge CLK);
    #1;
    doReset(2, 1'b0);
    runInstr("post_rst", 16'h1005, 0, 4, 0);

    runInstr("illegal", 16'hC000, 0, 5, 3);
    chk("illegal_halt", state[0], HALT);
    chk("illegal_nop_dec", nopTrace[1], DECODE);
    chk("illegal_nop_fetch", nopTrace[2], FETCH);
    doReset(1, 1'b0);

    runInstr("halt", 16'hF000, 0, 22, 20);
    chk("halt_held", trace[21].halted, 1'b1);
    h = trace[21];
    h.halted = 1'b0;
    h.state = 4'd0;
    chk("halt_quiet", h, 0);
    chk("halt_state", state[0], HALT);
    doReset(2, 1'b0);

    runInstr("final_nop", 16'h0000, 0, 2, 0);
    chk("expq_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
